riscv_apu_wb_buffer: RTL and testbench

- Sits directly downstream of the APU dispatcher.
- Captures APU results returned from the interconnect (valid, result, flags) together with the destination register chosen by the dispatcher.
- Writes each result to register-file write port B. The LSU has priority on that port, so results are held in an in-order FIFO whenever the port is busy.
- Flags pending writes back to the ID stage as read dependencies.

---
 rtl/apu_core_package.sv | 15 +
 rtl/riscv_apu_wb_fifo.sv | 62 ++++++
 rtl/riscv_apu_wb_buffer.sv | 123 ++++++++++++
 tb/tb_riscv_apu_wb_buffer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/apu_core_package.sv
// Shared constants and the write-back buffer entry layout for the APU result path.
package apu_core_package;

  localparam int APU_WB_DEPTH   = 2;
  localparam int APU_WB_ADDR_W  = 6;
  localparam int APU_WB_DATA_W  = 32;
  localparam int APU_WB_FLAGS_W = 5;

  typedef struct packed {
    logic [APU_WB_ADDR_W-1:0]  waddr;
    logic [APU_WB_DATA_W-1:0]  result;
    logic [APU_WB_FLAGS_W-1:0] flags;
  } apu_wb_entry_t;

endpackage

// File: rtl/riscv_apu_wb_fifo.sv
// In-order circular FIFO; head visible combinationally, push blocked only by the caller.
// Exposes the top TAG_W bits of every slot plus a per-slot valid mask for hazard compares.
module riscv_apu_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int TAG_W = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic [WIDTH-1:0]            data_i,
  output logic [WIDTH-1:0]            head_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [DEPTH-1:0][TAG_W-1:0] tag_o,
  output logic [DEPTH-1:0]            tag_vld_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               wptr_q, wptr_d;
  logic [PW-1:0]               rptr_q, rptr_d;
  logic [CW-1:0]               cnt_q, cnt_d;

  always_comb begin
    wptr_d = wptr_q + PW'(push_i);
    rptr_d = rptr_q + PW'(pop_i);
    cnt_d  = cnt_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PW-1:0] off;
    assign off          = PW'(g) - rptr_q;
    assign tag_o[g]     = mem_q[g][WIDTH-1 -: TAG_W];
    assign tag_vld_o[g] = (CW'(off) < cnt_q);
  end

endmodule

// File: rtl/riscv_apu_wb_buffer.sv
// APU result write-back to RF port B: zero-latency bypass when empty, else in-order FIFO; drops (sticky overflow_o) when full and port busy.
// Flag storage/output only with RISCV_APU_WB_FFLAGS_EN defined; otherwise fflags outputs are tied to zero.
module riscv_apu_wb_buffer
  import apu_core_package::*;
#(
  parameter int DEPTH       = APU_WB_DEPTH,
  parameter int DATA_WIDTH  = APU_WB_DATA_W,
  parameter int ADDR_WIDTH  = APU_WB_ADDR_W,
  parameter int FLAGS_WIDTH = APU_WB_FLAGS_W
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       apu_valid_i,
  input  logic [ADDR_WIDTH-1:0]      apu_waddr_i,
  input  logic [DATA_WIDTH-1:0]      apu_result_i,
  input  logic [FLAGS_WIDTH-1:0]     apu_flags_i,
  output logic                       apu_ready_o,
  input  logic                       wb_busy_i,
  output logic                       wb_we_o,
  output logic [ADDR_WIDTH-1:0]      wb_waddr_o,
  output logic [DATA_WIDTH-1:0]      wb_wdata_o,
  output logic                       fflags_we_o,
  output logic [FLAGS_WIDTH-1:0]     fflags_o,
  input  logic [2:0][ADDR_WIDTH-1:0] read_regs_i,
  input  logic [2:0]                 read_regs_valid_i,
  output logic                       read_dep_o,
  output logic                       pending_o,
  output logic                       overflow_o
);

`ifdef RISCV_APU_WB_FFLAGS_EN
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  waddr;
    logic [DATA_WIDTH-1:0]  result;
    logic [FLAGS_WIDTH-1:0] flags;
  } entry_t;
`else
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] result;
  } entry_t;
`endif

  localparam int EW = $bits(entry_t);

  entry_t                           in_entry, head;
  logic [EW-1:0]                    head_raw;
  logic                             fifo_full, fifo_empty;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_waddr;
  logic [DEPTH-1:0]                 ent_vld;
  logic                             bypass, push, pop, drop;
  logic                             overflow_q, overflow_d;

  always_comb begin
    in_entry        = '0;
    in_entry.waddr  = apu_waddr_i;
    in_entry.result = apu_result_i;
`ifdef RISCV_APU_WB_FFLAGS_EN
    in_entry.flags  = apu_flags_i;
`endif
  end

  assign head = entry_t'(head_raw);

  riscv_apu_wb_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .TAG_W (ADDR_WIDTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (push),
    .pop_i     (pop),
    .data_i    (in_entry),
    .head_o    (head_raw),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .tag_o     (ent_waddr),
    .tag_vld_o (ent_vld)
  );

  // Port B is shared with the LSU, which always wins.
  assign bypass      = fifo_empty & apu_valid_i & ~wb_busy_i;
  assign pop         = ~fifo_empty & ~wb_busy_i;
  assign apu_ready_o = ~fifo_full | pop;
  assign push        = apu_valid_i & apu_ready_o & ~bypass;
  assign drop        = apu_valid_i & ~apu_ready_o & ~bypass;
  assign overflow_d  = overflow_q | drop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) overflow_q <= 1'b0;
    else         overflow_q <= overflow_d;
  end

  assign wb_we_o    = bypass | pop;
  assign wb_waddr_o = pop ? head.waddr  : apu_waddr_i;
  assign wb_wdata_o = pop ? head.result : apu_result_i;
  assign pending_o  = ~fifo_empty;
  assign overflow_o = overflow_q;

`ifdef RISCV_APU_WB_FFLAGS_EN
  assign fflags_we_o = wb_we_o;
  assign fflags_o    = pop ? head.flags : apu_flags_i;
`else
  logic unused_flags;
  assign unused_flags = ^apu_flags_i;
  assign fflags_we_o  = 1'b0;
  assign fflags_o     = '0;
`endif

  always_comb begin
    read_dep_o = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (read_regs_valid_i[i]) begin
        if (apu_valid_i && !bypass && apu_waddr_i == read_regs_i[i]) read_dep_o = 1'b1;
        for (int j = 0; j < DEPTH; j++) begin
          if (ent_vld[j] && ent_waddr[j] == read_regs_i[i]) read_dep_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_apu_wb_buffer.sv
// Directed + randomized bench; a queue model checks every output on each falling edge.
module tb_riscv_apu_wb_buffer;
  localparam int DEPTH = 2, AW = 6, DW = 32, FW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                apu_valid_i, apu_ready_o, wb_busy_i;
  logic [AW-1:0]       apu_waddr_i, wb_waddr_o;
  logic [DW-1:0]       apu_result_i, wb_wdata_o;
  logic [FW-1:0]       apu_flags_i, fflags_o;
  logic                wb_we_o, fflags_we_o, read_dep_o, pending_o, overflow_o;
  logic [2:0][AW-1:0]  read_regs_i;
  logic [2:0]          read_regs_valid_i;

  riscv_apu_wb_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FLAGS_WIDTH(FW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .apu_valid_i(apu_valid_i), .apu_waddr_i(apu_waddr_i), .apu_result_i(apu_result_i),
    .apu_flags_i(apu_flags_i), .apu_ready_o(apu_ready_o), .wb_busy_i(wb_busy_i),
    .wb_we_o(wb_we_o), .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o),
    .fflags_we_o(fflags_we_o), .fflags_o(fflags_o),
    .read_regs_i(read_regs_i), .read_regs_valid_i(read_regs_valid_i),
    .read_dep_o(read_dep_o), .pending_o(pending_o), .overflow_o(overflow_o)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: pending results as plain queues, plus a sticky drop flag.
  logic [AW-1:0] mq_addr[$];
  logic [DW-1:0] mq_data[$];
  logic [FW-1:0] mq_flags[$];
  bit            m_ovf;
  bit            e_byp, e_pop, e_rdy, e_we, e_dep;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [FW-1:0] e_flags;

  always @(negedge clk) begin
    if (!rst_n) begin
      mq_addr.delete(); mq_data.delete(); mq_flags.delete();
      m_ovf = 0;
      chk("rst_ready", apu_ready_o, 1);
      chk("rst_we", wb_we_o, 0);
      chk("rst_pending", pending_o, 0);
      chk("rst_overflow", overflow_o, 0);
      chk("rst_fflags_we", fflags_we_o, 0);
    end else begin
      e_byp = (mq_addr.size() == 0) && apu_valid_i && !wb_busy_i;
      e_pop = (mq_addr.size() != 0) && !wb_busy_i;
      e_rdy = (mq_addr.size() < DEPTH) || e_pop;
      e_we  = e_byp || e_pop;
      e_addr  = e_pop ? mq_addr[0]  : apu_waddr_i;
      e_data  = e_pop ? mq_data[0]  : apu_result_i;
      e_flags = e_pop ? mq_flags[0] : apu_flags_i;
      e_dep = 0;
      for (int i = 0; i < 3; i++) begin
        if (read_regs_valid_i[i]) begin
          foreach (mq_addr[k]) if (mq_addr[k] == read_regs_i[i]) e_dep = 1;
          if (apu_valid_i && !e_byp && apu_waddr_i == read_regs_i[i]) e_dep = 1;
        end
      end
      chk("ready", apu_ready_o, e_rdy);
      chk("wb_we", wb_we_o, e_we);
      if (e_we) begin
        chk("wb_waddr", wb_waddr_o, e_addr);
        chk("wb_wdata", wb_wdata_o, e_data);
      end
`ifdef RISCV_APU_WB_FFLAGS_EN
      chk("fflags_we", fflags_we_o, e_we);
      if (e_we) chk("fflags", fflags_o, e_flags);
`else
      chk("fflags_we", fflags_we_o, 0);
      chk("fflags", fflags_o, 0);
`endif
      chk("pending", pending_o, mq_addr.size() != 0);
      chk("overflow", overflow_o, m_ovf);
      chk("read_dep", read_dep_o, e_dep);
      if (e_pop) begin
        void'(mq_addr.pop_front()); void'(mq_data.pop_front()); void'(mq_flags.pop_front());
      end
      if (apu_valid_i && !e_byp) begin
        if (e_rdy) begin
          mq_addr.push_back(apu_waddr_i); mq_data.push_back(apu_result_i); mq_flags.push_back(apu_flags_i);
        end else m_ovf = 1;
      end
    end
  end

  task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [FW-1:0] f, input logic b);
    @(posedge clk); #1;
    apu_valid_i = v; apu_waddr_i = a; apu_result_i = d; apu_flags_i = f; wb_busy_i = b;
  endtask

  task automatic idle(input logic b);
    step(1'b0, '0, '0, '0, b);
  endtask

  initial begin
    rst_n = 1'b0;
    apu_valid_i = 0; apu_waddr_i = '0; apu_result_i = '0; apu_flags_i = '0; wb_busy_i = 0;
    read_regs_i = '0; read_regs_valid_i = '0;
    idle(0); idle(0);
    #2;
    chk("lit_reset_ready", apu_ready_o, 1);
    chk("lit_reset_pending", pending_o, 0);
    rst_n = 1'b1;

    // Zero-latency bypass into an empty buffer.
    step(1, 6'd5, 32'hDEADBEEF, 5'd0, 0); #2;
    chk("lit_bypass_we", wb_we_o, 1);
    chk("lit_bypass_waddr", wb_waddr_o, 5);
    chk("lit_bypass_wdata", wb_wdata_o, 32'hDEADBEEF);
    chk("lit_bypass_pending", pending_o, 0);

    // Port busy for three cycles: two results queue, then drain in order.
    step(1, 6'd3, 32'h33, 5'd0, 1);
    step(1, 6'd7, 32'h77, 5'd0, 1);
    idle(1); #2;
    chk("lit_queued_pending", pending_o, 1);
    chk("lit_queued_ready", apu_ready_o, 0);
    idle(0); #2;
    chk("lit_drain0_we", wb_we_o, 1);
    chk("lit_drain0_waddr", wb_waddr_o, 3);
    idle(0); #2;
    chk("lit_drain1_waddr", wb_waddr_o, 7);
    idle(0); #2;
    chk("lit_drained_we", wb_we_o, 0);

    // Full FIFO with simultaneous pop and push.
    step(1, 6'd1, 32'h11, 5'd0, 1);
    step(1, 6'd2, 32'h22, 5'd0, 1);
    step(1, 6'd9, 32'h99, 5'd0, 0); #2;
    chk("lit_fullpp_waddr", wb_waddr_o, 1);
    chk("lit_fullpp_ready", apu_ready_o, 1);
    idle(1); #2;
    chk("lit_fullpp_still_full", apu_ready_o, 0);
    idle(0); #2;
    chk("lit_fullpp_next", wb_waddr_o, 2);
    idle(0); #2;
    chk("lit_fullpp_last", wb_waddr_o, 9);
    idle(0); #2;
    chk("lit_fullpp_no_ovf", overflow_o, 0);

    // Dependency on a pending entry.
    step(1, 6'd12, 32'hC, 5'd0, 1);
    idle(1);
    read_regs_i[1] = 6'd12; read_regs_valid_i = 3'b010; #2;
    chk("lit_dep_hit", read_dep_o, 1);
    read_regs_valid_i = 3'b000; #1;
    chk("lit_dep_masked", read_dep_o, 0);

    // Overflow: full and busy drops the result; sticky until reset.
    step(1, 6'd13, 32'hD, 5'd0, 1);
    step(1, 6'd14, 32'hE, 5'd0, 1);
    idle(1); #2;
    chk("lit_ovf_set", overflow_o, 1);
    idle(0);
    idle(1); #2;
    chk("lit_ovf_sticky", overflow_o, 1);
    chk("lit_one_pending", pending_o, 1);

    // Asynchronous reset with one entry pending.
    wb_busy_i = 0; rst_n = 1'b0; #1;
    chk("lit_arst_pending", pending_o, 0);
    chk("lit_arst_ovf", overflow_o, 0);
    chk("lit_arst_ready", apu_ready_o, 1);
    idle(0);
    rst_n = 1'b1;
    step(1, 6'd4, 32'h44, 5'b10001, 0); #2;
    chk("lit_post_rst_bypass", wb_we_o, 1);
    chk("lit_post_rst_waddr", wb_waddr_o, 4);
`ifdef RISCV_APU_WB_FFLAGS_EN
    chk("lit_fflags_we", fflags_we_o, 1);
    chk("lit_fflags", fflags_o, 5'b10001);
`else
    chk("lit_fflags_off", fflags_o, 0);
`endif

    // Randomized traffic: a light phase, then a reset, then a heavy phase.
    for (int ph = 0; ph < 2; ph++) begin
      for (int n = 0; n < 1200; n++) begin
        step(($urandom % (ph == 0 ? 4 : 2)) == 0, AW'($urandom % 16), $urandom,
             FW'($urandom), ($urandom % (ph == 0 ? 3 : 2)) == 0);
        for (int i = 0; i < 3; i++) read_regs_i[i] = AW'($urandom % 16);
        read_regs_valid_i = 3'($urandom);
      end
      idle(0);
      read_regs_valid_i = '0;
      rst_n = 1'b0;
      idle(0);
      rst_n = 1'b1;
    end
    idle(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
